// File: rtl/ex_stage.sv
// RV32I execute stage with EX/MEM pipeline register: operand forwarding, ALU, branch/jump resolution.
// Optional macro EX_FORWARD_EN enables MEM/WB operand forwarding; without it operands come straight from ID_EX.
module ex_stage #(
  parameter int          XLEN    = 32,
  parameter logic [31:0] RST_PC4 = 32'h4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [6:0]      EX_opcode,
  input  logic            EX_cntl_MemWrite,
  input  logic            EX_cntl_MemRead,
  input  logic            EX_cntl_RegWrite,
  input  logic [2:0]      EX_sel_MemToReg,
  input  logic [1:0]      EX_sel_ALUSrc,
  input  logic [3:0]      EX_funct,
  input  logic [3:0]      EX_ALUOp,
  input  logic [4:0]      EX_ReadRegNum1,
  input  logic [4:0]      EX_ReadRegNum2,
  input  logic [4:0]      EX_WriteRegNum,
  input  logic [XLEN-1:0] EX_ReadRegData1,
  input  logic [XLEN-1:0] EX_ReadRegData2,
  input  logic [XLEN-1:0] EX_immediate,
  input  logic [XLEN-1:0] EX_PC,
  input  logic            WB_cntl_RegWrite,
  input  logic [4:0]      WB_WriteRegNum,
  input  logic [XLEN-1:0] WB_WriteData,
  input  logic            MEM_stall,
  output logic            EX_PCSrc,
  output logic [XLEN-1:0] EX_branchTarget,
  output logic            EX_flush,
  output logic            MEM_cntl_MemWrite,
  output logic            MEM_cntl_MemRead,
  output logic            MEM_cntl_RegWrite,
  output logic [2:0]      MEM_sel_MemToReg,
  output logic [3:0]      MEM_funct,
  output logic [4:0]      MEM_WriteRegNum,
  output logic [XLEN-1:0] MEM_ALUResult,
  output logic [XLEN-1:0] MEM_StoreData,
  output logic [XLEN-1:0] MEM_immediate,
  output logic [XLEN-1:0] MEM_branchAddr,
  output logic [XLEN-1:0] MEM_PCplus4
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic            mem_wr_q, mem_rd_q, mem_regwr_q;
  logic [2:0]      mem_sel_q;
  logic [3:0]      mem_funct_q;
  logic [4:0]      mem_rdnum_q;
  logic [XLEN-1:0] mem_alu_q, mem_store_q, mem_imm_q, mem_baddr_q, mem_pc4_q;

  logic [XLEN-1:0] op_a_fwd, op_b_fwd, mem_fwd_val;
  logic [XLEN-1:0] alu_a, alu_b, alu_res;
  logic [4:0]      shamt;
  logic [XLEN-1:0] branch_addr, pc_plus4, jalr_sum, target;
  logic            taken;

  // A load in MEM cannot be forwarded (hazard unit bubbles); it falls back to the ALU field.
  always_comb begin
    case (mem_sel_q)
      3'b010:  mem_fwd_val = mem_imm_q;
      3'b011:  mem_fwd_val = mem_baddr_q;
      3'b100:  mem_fwd_val = mem_pc4_q;
      default: mem_fwd_val = mem_alu_q;
    endcase
  end

`ifdef EX_FORWARD_EN
  always_comb begin
    op_a_fwd = EX_ReadRegData1;
    if (EX_ReadRegNum1 != 5'd0 && mem_regwr_q && mem_rdnum_q == EX_ReadRegNum1)
      op_a_fwd = mem_fwd_val;
    else if (EX_ReadRegNum1 != 5'd0 && WB_cntl_RegWrite && WB_WriteRegNum == EX_ReadRegNum1)
      op_a_fwd = WB_WriteData;
    op_b_fwd = EX_ReadRegData2;
    if (EX_ReadRegNum2 != 5'd0 && mem_regwr_q && mem_rdnum_q == EX_ReadRegNum2)
      op_b_fwd = mem_fwd_val;
    else if (EX_ReadRegNum2 != 5'd0 && WB_cntl_RegWrite && WB_WriteRegNum == EX_ReadRegNum2)
      op_b_fwd = WB_WriteData;
  end
`else
  assign op_a_fwd = EX_ReadRegData1;
  assign op_b_fwd = EX_ReadRegData2;
  logic unused_fwd;
  assign unused_fwd = ^{EX_ReadRegNum1, EX_ReadRegNum2, WB_cntl_RegWrite, WB_WriteRegNum,
                        WB_WriteData, mem_fwd_val};
`endif

  always_comb begin
    alu_a = (EX_sel_ALUSrc == 2'b10) ? EX_PC : op_a_fwd;
    alu_b = (EX_sel_ALUSrc == 2'b00) ? op_b_fwd : EX_immediate;
    shamt = alu_b[4:0];
    case (EX_ALUOp)
      4'd1:    alu_res = alu_a - alu_b;
      4'd2:    alu_res = alu_a << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      4'd5:    alu_res = alu_a ^ alu_b;
      4'd6:    alu_res = alu_a >> shamt;
      4'd7:    alu_res = $signed(alu_a) >>> shamt;
      4'd8:    alu_res = alu_a | alu_b;
      4'd9:    alu_res = alu_a & alu_b;
      default: alu_res = alu_a + alu_b;
    endcase
  end

  assign branch_addr = EX_PC + EX_immediate;
  assign pc_plus4    = EX_PC + 32'd4;
  assign jalr_sum    = op_a_fwd + EX_immediate;

  always_comb begin
    taken  = 1'b0;
    target = branch_addr;
    case (EX_opcode)
      OP_BRANCH: begin
        case (EX_funct[2:0])
          3'b000:  taken = (op_a_fwd == op_b_fwd);
          3'b001:  taken = (op_a_fwd != op_b_fwd);
          3'b100:  taken = ($signed(op_a_fwd) <  $signed(op_b_fwd));
          3'b101:  taken = ($signed(op_a_fwd) >= $signed(op_b_fwd));
          3'b110:  taken = (op_a_fwd <  op_b_fwd);
          3'b111:  taken = (op_a_fwd >= op_b_fwd);
          default: taken = 1'b0;
        endcase
      end
      OP_JAL:  taken = 1'b1;
      OP_JALR: begin
        taken  = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

  // A stalled redirect is withheld so it fires exactly once, when the instruction leaves EX.
  assign EX_PCSrc        = taken & ~MEM_stall & reset_n;
  assign EX_flush        = EX_PCSrc;
  assign EX_branchTarget = target;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_regwr_q <= 1'b0;
      mem_sel_q   <= 3'd0;
      mem_funct_q <= 4'd0;
      mem_rdnum_q <= 5'd0;
      mem_alu_q   <= '0;
      mem_store_q <= '0;
      mem_imm_q   <= '0;
      mem_baddr_q <= '0;
      mem_pc4_q   <= RST_PC4;
    end else if (!MEM_stall) begin
      mem_wr_q    <= EX_cntl_MemWrite;
      mem_rd_q    <= EX_cntl_MemRead;
      mem_regwr_q <= EX_cntl_RegWrite;
      mem_sel_q   <= EX_sel_MemToReg;
      mem_funct_q <= EX_funct;
      mem_rdnum_q <= EX_WriteRegNum;
      mem_alu_q   <= alu_res;
      mem_store_q <= op_b_fwd;
      mem_imm_q   <= EX_immediate;
      mem_baddr_q <= branch_addr;
      mem_pc4_q   <= pc_plus4;
    end
  end

  assign MEM_cntl_MemWrite = mem_wr_q;
  assign MEM_cntl_MemRead  = mem_rd_q;
  assign MEM_cntl_RegWrite = mem_regwr_q;
  assign MEM_sel_MemToReg  = mem_sel_q;
  assign MEM_funct         = mem_funct_q;
  assign MEM_WriteRegNum   = mem_rdnum_q;
  assign MEM_ALUResult     = mem_alu_q;
  assign MEM_StoreData     = mem_store_q;
  assign MEM_immediate     = mem_imm_q;
  assign MEM_branchAddr    = mem_baddr_q;
  assign MEM_PCplus4       = mem_pc4_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: behavioural model checked every cycle plus hand-computed literal checks.
// Follows the DUT build: forwarding expectations apply only when EX_FORWARD_EN is defined.
module tb_ex_stage;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [6:0]  EX_opcode;
  logic        EX_cntl_MemWrite, EX_cntl_MemRead, EX_cntl_RegWrite;
  logic [2:0]  EX_sel_MemToReg;
  logic [1:0]  EX_sel_ALUSrc;
  logic [3:0]  EX_funct, EX_ALUOp;
  logic [4:0]  EX_ReadRegNum1, EX_ReadRegNum2, EX_WriteRegNum;
  logic [31:0] EX_ReadRegData1, EX_ReadRegData2, EX_immediate, EX_PC;
  logic        WB_cntl_RegWrite;
  logic [4:0]  WB_WriteRegNum;
  logic [31:0] WB_WriteData;
  logic        MEM_stall;
  logic        EX_PCSrc, EX_flush;
  logic [31:0] EX_branchTarget;
  logic        MEM_cntl_MemWrite, MEM_cntl_MemRead, MEM_cntl_RegWrite;
  logic [2:0]  MEM_sel_MemToReg;
  logic [3:0]  MEM_funct;
  logic [4:0]  MEM_WriteRegNum;
  logic [31:0] MEM_ALUResult, MEM_StoreData, MEM_immediate, MEM_branchAddr, MEM_PCplus4;

  ex_stage dut (
    .clk(clk), .reset_n(reset_n), .EX_opcode(EX_opcode),
    .EX_cntl_MemWrite(EX_cntl_MemWrite), .EX_cntl_MemRead(EX_cntl_MemRead),
    .EX_cntl_RegWrite(EX_cntl_RegWrite), .EX_sel_MemToReg(EX_sel_MemToReg),
    .EX_sel_ALUSrc(EX_sel_ALUSrc), .EX_funct(EX_funct), .EX_ALUOp(EX_ALUOp),
    .EX_ReadRegNum1(EX_ReadRegNum1), .EX_ReadRegNum2(EX_ReadRegNum2),
    .EX_WriteRegNum(EX_WriteRegNum), .EX_ReadRegData1(EX_ReadRegData1),
    .EX_ReadRegData2(EX_ReadRegData2), .EX_immediate(EX_immediate), .EX_PC(EX_PC),
    .WB_cntl_RegWrite(WB_cntl_RegWrite), .WB_WriteRegNum(WB_WriteRegNum),
    .WB_WriteData(WB_WriteData), .MEM_stall(MEM_stall),
    .EX_PCSrc(EX_PCSrc), .EX_branchTarget(EX_branchTarget), .EX_flush(EX_flush),
    .MEM_cntl_MemWrite(MEM_cntl_MemWrite), .MEM_cntl_MemRead(MEM_cntl_MemRead),
    .MEM_cntl_RegWrite(MEM_cntl_RegWrite), .MEM_sel_MemToReg(MEM_sel_MemToReg),
    .MEM_funct(MEM_funct), .MEM_WriteRegNum(MEM_WriteRegNum),
    .MEM_ALUResult(MEM_ALUResult), .MEM_StoreData(MEM_StoreData),
    .MEM_immediate(MEM_immediate), .MEM_branchAddr(MEM_branchAddr),
    .MEM_PCplus4(MEM_PCplus4)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- reference model: the architectural meaning of one EX instruction ----
  logic        m_wr, m_rd, m_regwr;
  logic [2:0]  m_sel;
  logic [3:0]  m_funct;
  logic [4:0]  m_rdnum;
  logic [31:0] m_alu, m_store, m_imm, m_baddr, m_pc4;

  function automatic logic [31:0] operand(input logic [4:0] num, input logic [31:0] rf);
`ifdef EX_FORWARD_EN
    if (num == 0) return rf;
    if (m_regwr && m_rdnum == num) begin
      if (m_sel == 3'd2) return m_imm;
      if (m_sel == 3'd3) return m_baddr;
      if (m_sel == 3'd4) return m_pc4;
      return m_alu;
    end
    if (WB_cntl_RegWrite && WB_WriteRegNum == num) return WB_WriteData;
`endif
    return rf;
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic is_taken(input logic [31:0] a, input logic [31:0] b);
    if (EX_opcode == 7'b1101111 || EX_opcode == 7'b1100111) return 1'b1;
    if (EX_opcode != 7'b1100011) return 1'b0;
    case (EX_funct[2:0])
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return signed'(a) <  signed'(b);
      3'b101: return signed'(a) >= signed'(b);
      3'b110: return a <  b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic [31:0] a, b, r;
    if (!reset_n) begin
      {m_wr, m_rd, m_regwr, m_sel, m_funct, m_rdnum} = '0;
      {m_alu, m_store, m_imm, m_baddr} = '0;
      m_pc4 = 32'h4;
    end else if (!MEM_stall) begin
      a = operand(EX_ReadRegNum1, EX_ReadRegData1);
      b = operand(EX_ReadRegNum2, EX_ReadRegData2);
      r = alu(EX_ALUOp, (EX_sel_ALUSrc == 2'b10) ? EX_PC : a,
              (EX_sel_ALUSrc == 2'b00) ? b : EX_immediate);
      m_wr = EX_cntl_MemWrite; m_rd = EX_cntl_MemRead; m_regwr = EX_cntl_RegWrite;
      m_sel = EX_sel_MemToReg; m_funct = EX_funct; m_rdnum = EX_WriteRegNum;
      m_alu = r; m_store = b; m_imm = EX_immediate;
      m_baddr = EX_PC + EX_immediate; m_pc4 = EX_PC + 4;
    end
  end

  always @(negedge clk) begin
    logic [31:0] a, b, tgt;
    logic t;
    if (cmp_en) begin
      a = operand(EX_ReadRegNum1, EX_ReadRegData1);
      b = operand(EX_ReadRegNum2, EX_ReadRegData2);
      t = is_taken(a, b);
      tgt = (EX_opcode == 7'b1100111) ? ((a + EX_immediate) & 32'hFFFF_FFFE) : EX_PC + EX_immediate;
      chk("m_PCSrc", {31'd0, EX_PCSrc}, {31'd0, t && !MEM_stall && reset_n});
      chk("m_flush", {31'd0, EX_flush}, {31'd0, t && !MEM_stall && reset_n});
      if (t) chk("m_target", EX_branchTarget, tgt);
      chk("m_ctl", {29'd0, MEM_cntl_MemWrite, MEM_cntl_MemRead, MEM_cntl_RegWrite}, {29'd0, m_wr, m_rd, m_regwr});
      chk("m_sel_funct_rd", {20'd0, MEM_sel_MemToReg, MEM_funct, MEM_WriteRegNum}, {20'd0, m_sel, m_funct, m_rdnum});
      chk("m_alu", MEM_ALUResult, m_alu);
      chk("m_store", MEM_StoreData, m_store);
      chk("m_imm", MEM_immediate, m_imm);
      chk("m_baddr", MEM_branchAddr, m_baddr);
      chk("m_pc4", MEM_PCplus4, m_pc4);
    end
  end

  // ---- stimulus ----
  task automatic nop();
    EX_opcode = '0; EX_cntl_MemWrite = 0; EX_cntl_MemRead = 0; EX_cntl_RegWrite = 0;
    EX_sel_MemToReg = '0; EX_sel_ALUSrc = '0; EX_funct = '0; EX_ALUOp = '0;
    EX_ReadRegNum1 = '0; EX_ReadRegNum2 = '0; EX_WriteRegNum = '0;
    EX_ReadRegData1 = '0; EX_ReadRegData2 = '0; EX_immediate = '0; EX_PC = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic [6:0] opc, input logic [3:0] op, input logic [1:0] src,
                        input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                        input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] rd);
    nop();
    EX_opcode = opc; EX_ALUOp = op; EX_sel_ALUSrc = src; EX_cntl_RegWrite = 1;
    EX_ReadRegNum1 = rs1; EX_ReadRegData1 = d1; EX_ReadRegNum2 = rs2; EX_ReadRegData2 = d2;
    EX_immediate = imm; EX_WriteRegNum = rd;
  endtask

  task automatic branch(input logic [2:0] f3, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] pc, input logic [31:0] imm);
    nop();
    EX_opcode = 7'b1100011; EX_funct = {1'b0, f3}; EX_ALUOp = 4'd1;
    EX_ReadRegNum1 = 5'd11; EX_ReadRegData1 = d1; EX_ReadRegNum2 = 5'd12; EX_ReadRegData2 = d2;
    EX_PC = pc; EX_immediate = imm;
  endtask

  initial begin
    nop();
    WB_cntl_RegWrite = 0; WB_WriteRegNum = '0; WB_WriteData = '0; MEM_stall = 0;
    #12;
    chk("rst_pc4", MEM_PCplus4, 32'h4);
    chk("rst_alu", MEM_ALUResult, 32'h0);
    chk("rst_regwr", {31'd0, MEM_cntl_RegWrite}, 32'd0);
    chk("rst_pcsrc", {31'd0, EX_PCSrc}, 32'd0);
    @(negedge clk); reset_n = 1; cmp_en = 1;
    step();

    alu_op(7'b0110011, 4'd0, 2'b00, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd3);
    step();
    chk("add_res", MEM_ALUResult, 32'd12);
    chk("add_regwr", {31'd0, MEM_cntl_RegWrite}, 32'd1);
    chk("add_rd", {27'd0, MEM_WriteRegNum}, 32'd3);

    WB_cntl_RegWrite = 1; WB_WriteRegNum = 5'd3; WB_WriteData = 32'd99;
    alu_op(7'b0010011, 4'd0, 2'b01, 5'd3, 32'd50, 5'd0, 32'd0, 32'd1, 5'd4);
    step();
`ifdef EX_FORWARD_EN
    chk("fwd_mem_prio", MEM_ALUResult, 32'd13);
`else
    chk("fwd_off_a", MEM_ALUResult, 32'd51);
`endif
    WB_WriteRegNum = 5'd0;
    alu_op(7'b0010011, 4'd0, 2'b01, 5'd0, 32'd0, 5'd0, 32'd0, 32'd1, 5'd5);
    step();
    chk("fwd_x0", MEM_ALUResult, 32'd1);
    WB_WriteRegNum = 5'd3;
    alu_op(7'b0010011, 4'd0, 2'b01, 5'd3, 32'd50, 5'd0, 32'd0, 32'd1, 5'd6);
    step();
`ifdef EX_FORWARD_EN
    chk("fwd_wb", MEM_ALUResult, 32'd100);
`else
    chk("fwd_off_b", MEM_ALUResult, 32'd51);
`endif
    WB_cntl_RegWrite = 0;

    branch(3'b000, 32'h55, 32'h55, 32'h100, 32'h20);
    #1;
    chk("beq_pcsrc", {31'd0, EX_PCSrc}, 32'd1);
    chk("beq_flush", {31'd0, EX_flush}, 32'd1);
    chk("beq_target", EX_branchTarget, 32'h120);
    step();
    chk("beq_baddr", MEM_branchAddr, 32'h120);
    branch(3'b001, 32'h55, 32'h55, 32'h100, 32'h20);
    #1;
    chk("bne_pcsrc", {31'd0, EX_PCSrc}, 32'd0);
    step();
    for (int f = 2; f < 8; f++) begin
      branch(3'(f), 32'hFFFF_FFF0, 32'h10, 32'h200, 32'hFFFF_FFF8);
      step();
    end

    alu_op(7'b1100111, 4'd0, 2'b01, 5'd8, 32'h203, 5'd0, 32'd0, 32'd4, 5'd1);
    EX_sel_MemToReg = 3'b100; EX_PC = 32'h300;
    #1;
    chk("jalr_target", EX_branchTarget, 32'h206);
    step();
    chk("jalr_pc4", MEM_PCplus4, 32'h304);
    alu_op(7'b0010011, 4'd0, 2'b01, 5'd1, 32'h77, 5'd0, 32'd0, 32'd0, 5'd2);
    step();
`ifdef EX_FORWARD_EN
    chk("fwd_pc4", MEM_ALUResult, 32'h304);
`else
    chk("fwd_off_c", MEM_ALUResult, 32'h77);
`endif

    nop(); EX_opcode = 7'b1101111; EX_PC = 32'h400; EX_immediate = 32'h10;
    #1;
    chk("jal_target", EX_branchTarget, 32'h410);
    step();

    nop(); EX_opcode = 7'b0100011; EX_cntl_MemWrite = 1; EX_sel_ALUSrc = 2'b01; EX_funct = 4'b0010;
    EX_ReadRegNum1 = 5'd20; EX_ReadRegData1 = 32'h1000; EX_ReadRegNum2 = 5'd21;
    EX_ReadRegData2 = 32'hDEAD_BEEF; EX_immediate = 32'd8;
    step();
    chk("sw_data", MEM_StoreData, 32'hDEAD_BEEF);
    chk("sw_addr", MEM_ALUResult, 32'h1008);

    for (int op = 0; op < 16; op++) begin
      alu_op(7'b0110011, 4'(op), 2'b00, 5'd13, 32'h8000_0F0F, 5'd14, 32'h24, 32'd0, 5'd15);
      step();
    end
    alu_op(7'b0010111, 4'd0, 2'b10, 5'd0, 32'd0, 5'd0, 32'd0, 32'h1000, 5'd16);
    EX_PC = 32'h80;
    step();
    chk("auipc", MEM_ALUResult, 32'h1080);
    alu_op(7'b0110011, 4'd7, 2'b00, 5'd9, 32'h8000_0000, 5'd10, 32'd4, 32'd0, 5'd5);
    step();
    chk("sra", MEM_ALUResult, 32'hF800_0000);

    branch(3'b000, 32'h1, 32'h1, 32'h500, 32'h40);
    MEM_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pcsrc", {31'd0, EX_PCSrc}, 32'd0);
      step();
      chk("stall_hold", MEM_ALUResult, 32'hF800_0000);
    end
    MEM_stall = 0;
    #1;
    chk("release_pcsrc", {31'd0, EX_PCSrc}, 32'd1);
    step();
    chk("release_baddr", MEM_branchAddr, 32'h540);
    nop();
    #1;
    chk("after_release_pcsrc", {31'd0, EX_PCSrc}, 32'd0);
    step();

    alu_op(7'b0110011, 4'd0, 2'b00, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd3);
    step();
    nop(); EX_opcode = 7'b1101111; EX_PC = 32'h600; EX_immediate = 32'h8;
    MEM_stall = 1;
    #3 reset_n = 0;
    #2;
    chk("rst_mid_alu", MEM_ALUResult, 32'h0);
    chk("rst_mid_pc4", MEM_PCplus4, 32'h4);
    chk("rst_mid_regwr", {31'd0, MEM_cntl_RegWrite}, 32'd0);
    chk("rst_mid_pcsrc", {31'd0, EX_PCSrc}, 32'd0);
    @(negedge clk); reset_n = 1; MEM_stall = 0; nop();
    step(); step();
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
